// File: rtl/karatsuba2_digit_serial_gf2.sv
// ---------------------------------------------------------------------------
// karatsuba2_digit_serial_gf2
//   2-way Karatsuba carry-less multiplier over GF(2)[x]: c = a * b.
//   Operands are split into hi/lo halves of H = (WIDTH+1)/2 bits. Three
//   half-size products (hi*hi, lo*lo, (hi^lo)*(hi^lo)) are accumulated
//   concurrently, DIGIT multiplier bits per cycle, over NC cycles, then
//   combined in one cycle with XOR only.
//
//   Handshake (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. The producer holds valid (and data) until
//   that edge; in_ready is high only in IDLE, out_valid only in DONE, and c
//   is held stable while out_valid is high.
//
//   Timing: accept edge to out_valid high is NC+2 cycles.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-low reset
//   abort      in   1          (only with KARATSUBA_ABORT_EN) drop the
//                              operation in flight during MUL/COMB
//   in_valid   in   1          a,b valid
//   in_ready   out  1          block can accept operands
//   a, b       in   WIDTH      operands
//   out_valid  out  1          c valid
//   out_ready  in   1          downstream accepts c
//   c          out  2*WIDTH    carry-less product (top bit always 0)
//
// Configuration macro: KARATSUBA_ABORT_EN (adds the abort input).
// Debug: FSM state is the internal r_state register (state_t).
// ---------------------------------------------------------------------------
module karatsuba2_digit_serial_gf2 #(
  parameter int WIDTH = 283,
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst,
`ifdef KARATSUBA_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c
);

  localparam int H  = (WIDTH + 1) / 2;
  localparam int NC = (H + DIGIT - 1) / DIGIT;
  localparam int AW = 2 * H - 1;            // half-product width
  localparam int PW = 4 * H;                // combine width, >= 2*WIDTH
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_COMB, S_DONE} state_t;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [2*WIDTH-1:0]  r_c;
  // Multiplier bits shift right by DIGIT each cycle and multiplicands shift
  // left by DIGIT, so the digit step always looks at x[DIGIT-1:0] and the
  // shift distance k*DIGIT is carried in the operand registers. Bits past
  // H shift in as zero, which makes the partial last digit contribute nothing.
  logic [H-1:0]        r_x_hi, r_x_lo, r_x_s;
  logic [AW-1:0]       r_y_hi, r_y_lo, r_y_s;
  logic [AW-1:0]       r_acc_hi, r_acc_lo, r_acc_s;

  logic                w_abort;
  logic [H-1:0]        w_a_hi, w_a_lo, w_b_hi, w_b_lo;
  logic [AW-1:0]       w_nx_hi, w_nx_lo, w_nx_s, w_mid;
  logic [2*WIDTH-1:0]  w_prod;

`ifdef KARATSUBA_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Odd WIDTH: hi gets a zero top bit from the shift.
  assign w_a_hi = H'(a >> H);
  assign w_a_lo = a[H-1:0];
  assign w_b_hi = H'(b >> H);
  assign w_b_lo = b[H-1:0];

  function automatic logic [AW-1:0] digit_step(input logic [AW-1:0] acc,
                                               input logic [H-1:0]  x,
                                               input logic [AW-1:0] y);
    logic [AW-1:0] r;
    r = acc;
    for (int j = 0; j < DIGIT; j++) begin
      if (x[j]) r = r ^ (y << j);
    end
    return r;
  endfunction

  assign w_nx_hi = digit_step(r_acc_hi, r_x_hi, r_y_hi);
  assign w_nx_lo = digit_step(r_acc_lo, r_x_lo, r_y_lo);
  assign w_nx_s  = digit_step(r_acc_s,  r_x_s,  r_y_s);

  // In GF(2) the Karatsuba middle term is a plain XOR of the three products.
  assign w_mid  = r_acc_s ^ r_acc_hi ^ r_acc_lo;
  assign w_prod = (2*WIDTH)'((PW'(r_acc_hi) << (2 * H)) ^
                             (PW'(w_mid) << H) ^
                             PW'(r_acc_lo));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_x_hi      <= '0;
      r_x_lo      <= '0;
      r_x_s       <= '0;
      r_y_hi      <= '0;
      r_y_lo      <= '0;
      r_y_s       <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_acc_s     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          if (in_valid && r_in_ready) begin
            r_x_hi     <= w_a_hi;
            r_x_lo     <= w_a_lo;
            r_x_s      <= w_a_hi ^ w_a_lo;
            r_y_hi     <= AW'(w_b_hi);
            r_y_lo     <= AW'(w_b_lo);
            r_y_s      <= AW'(w_b_hi ^ w_b_lo);
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_acc_s    <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (w_abort) begin
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_acc_s    <= '0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_acc_hi <= w_nx_hi;
            r_acc_lo <= w_nx_lo;
            r_acc_s  <= w_nx_s;
            r_x_hi   <= r_x_hi >> DIGIT;
            r_x_lo   <= r_x_lo >> DIGIT;
            r_x_s    <= r_x_s >> DIGIT;
            r_y_hi   <= r_y_hi << DIGIT;
            r_y_lo   <= r_y_lo << DIGIT;
            r_y_s    <= r_y_s << DIGIT;
            if (r_k == KW'(NC - 1)) r_state <= S_COMB;
            else                    r_k     <= r_k + 1'b1;
          end
        end
        S_COMB: begin
          if (w_abort) begin
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_acc_s    <= '0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_c     <= w_prod;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // out_valid rises one cycle after entering DONE (registered output).
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;

endmodule
